// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : FSM state encodings (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor, the mirror of a 1-bit full-adder cell.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow-in
//   d  : difference bit, x - y - bi
//   bo : borrow-out
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x, or when the bits match and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are accepted on an in_valid/in_ready
// handshake, resolved one bit per clock LSB first through a single registered
// borrow, and returned on an out_valid/out_ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, b_in)
//   a, b, b_in          : minuend, subtrahend, borrow-in
//   out_valid, out_ready: result handshake (diff, b_out)
//   diff                : (a - b - b_in) mod 2^WIDTH
//   b_out               : 1 iff a < b + b_in
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               b_out_q, b_out_d;

  logic               cell_d;
  logic               cell_bo;

  full_sub_cell u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    b_out_d  = b_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = b_in;
          count_d  = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // New bit enters at the MSB so the LSB-first stream lands in order.
        diff_d   = WIDTH'({cell_d, diff_q} >> 1);
        borrow_d = cell_bo;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          b_out_d = cell_bo;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      b_out_q  <= b_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int unsigned W = 4;
  localparam int NVEC = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs [NVEC];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one operand set; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    a = av; b = bv; b_in = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; b_in = ~bi;  // later operand changes must not matter
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid timeout: got 0, expected 1");
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready after handoff", 32'(in_ready), 32'd1);
    check("out_valid after handoff", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{4'd3,  4'd4,  1'b0, 4'b1111, 1'b1};
    vecs[1] = '{4'd7,  4'd2,  1'b0, 4'b0101, 1'b0};
    vecs[2] = '{4'd15, 4'd10, 1'b0, 4'b0101, 1'b0};
    vecs[3] = '{4'd9,  4'd9,  1'b1, 4'b1111, 1'b1};
    vecs[4] = '{4'd0,  4'd0,  1'b1, 4'b1111, 1'b1};
    vecs[5] = '{4'd10, 4'd5,  1'b1, 4'b0100, 1'b0};
    vecs[6] = '{4'd8,  4'd3,  1'b0, 4'b0101, 1'b0};
    vecs[7] = '{4'd0,  4'd15, 1'b0, 4'b0001, 1'b1};
    vecs[8] = '{4'd15, 4'd0,  1'b1, 4'b1110, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset b_out", 32'(b_out), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      check("in_ready during shift", 32'(in_ready), 32'd0);
      wait_valid(lat);
      check("latency", 32'(lat), 32'd4);
      check("diff", 32'(diff), 32'(vecs[i].diff));
      check("b_out", 32'(b_out), 32'(vecs[i].bout));
      handoff();
    end

    // Back-pressure: result must hold while out_ready stays low.
    start_op(4'd3, 4'd4, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp diff", 32'(diff), 32'hf);
      check("bp b_out", 32'(b_out), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    handoff();

    // Back-to-back: in_valid stays high; second operand taken 1 cycle after handoff.
    a = 4'd7; b = 4'd2; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b first accepted", 32'(in_ready), 32'd0);
    a = 4'd9; b = 4'd9; b_in = 1'b1;  // ignored until the next IDLE
    wait_valid(lat);
    check("b2b latency 1", 32'(lat), 32'd4);
    check("b2b diff 1", 32'(diff), 32'h5);
    check("b2b b_out 1", 32'(b_out), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b in_ready after handoff", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b second accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("b2b latency 2", 32'(lat), 32'd4);
    check("b2b diff 2", 32'(diff), 32'hf);
    check("b2b b_out 2", 32'(b_out), 32'd1);
    handoff();

    // Reset at count==2 discards the transaction.
    start_op(4'd7, 4'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset diff", 32'(diff), 32'd0);
    check("mid reset b_out", 32'(b_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no out_valid after reset", 32'(out_valid), 32'd0);
    end
    start_op(4'd10, 4'd5, 1'b1);
    wait_valid(lat);
    check("post reset latency", 32'(lat), 32'd4);
    check("post reset diff", 32'(diff), 32'h4);
    check("post reset b_out", 32'(b_out), 32'd0);
    handoff();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
